// File: rtl/store_drain_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : store_drain_buffer_pkg
// Description : Shared widths, entry layout and drain-FSM encoding for the
//               committed-store drain buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package store_drain_buffer_pkg;

    localparam int ADDR_WIDTH     = 32;
    localparam int DATA_WIDTH     = 32;
    localparam int MASK_WIDTH     = DATA_WIDTH / 8;

    localparam int SB_DEPTH       = 4;
    localparam int SB_DEPTH_WIDTH = 2;

    // Entry layout {mask, addr, data}, data in the low bits.
    localparam int SB_DATA_LSB    = 0;
    localparam int SB_DATA_MSB    = SB_DATA_LSB + DATA_WIDTH - 1;
    localparam int SB_ADDR_LSB    = SB_DATA_MSB + 1;
    localparam int SB_ADDR_MSB    = SB_ADDR_LSB + ADDR_WIDTH - 1;
    localparam int SB_MASK_LSB    = SB_ADDR_MSB + 1;
    localparam int SB_MASK_MSB    = SB_MASK_LSB + MASK_WIDTH - 1;
    localparam int SB_ENTRY_WIDTH = SB_MASK_MSB + 1;

    typedef enum logic [0:0] {
        SB_IDLE = 1'b0,
        SB_REQ  = 1'b1
    } sb_state_t;

    // Packs one store into the buffer entry layout.
    function automatic logic [SB_ENTRY_WIDTH-1:0] sb_pack(
        input logic [MASK_WIDTH-1:0] mask,
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] data
    );
        return {mask, addr, data};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sb_forward_merge.sv
`default_nettype none
// ============================================================================
// Module      : sb_forward_merge
// Description : Combinational load lookup over the valid buffered stores.
//               Walks entries oldest to youngest so the youngest write of
//               each byte lane wins.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_forward_merge
    import store_drain_buffer_pkg::*;
#(
    parameter int DEPTH       = SB_DEPTH,
    parameter int DEPTH_WIDTH = SB_DEPTH_WIDTH
) (
    input  logic [DEPTH*SB_ENTRY_WIDTH-1:0] entries,
    input  logic [DEPTH_WIDTH-1:0]          rd_ptr,
    input  logic [DEPTH_WIDTH:0]            count,
    input  logic                            ld_check,
    input  logic [ADDR_WIDTH-1:0]           ld_addr,
    output logic [MASK_WIDTH-1:0]           fwd_mask,
    output logic [DATA_WIDTH-1:0]           fwd_data
);

    // Byte offset bits are excluded from the word match.
    localparam logic [ADDR_WIDTH-1:0] c_word_mask = ~ADDR_WIDTH'(3);

    // Oldest-to-youngest merge of every valid matching entry.
    always_comb begin
        logic [DEPTH_WIDTH-1:0]    w_idx;
        logic [SB_ENTRY_WIDTH-1:0] w_entry;
        logic [ADDR_WIDTH-1:0]     w_addr;
        fwd_mask = '0;
        fwd_data = '0;
        w_idx    = '0;
        w_entry  = '0;
        w_addr   = '0;
        if (ld_check) begin
            for (int i = 0; i < DEPTH; i++) begin
                w_idx   = rd_ptr + DEPTH_WIDTH'(i);
                w_entry = entries[int'(w_idx)*SB_ENTRY_WIDTH +: SB_ENTRY_WIDTH];
                w_addr  = w_entry[SB_ADDR_MSB:SB_ADDR_LSB];
                if (((DEPTH_WIDTH+1)'(i) < count) &&
                    (((w_addr ^ ld_addr) & c_word_mask) == '0)) begin
                    for (int b = 0; b < MASK_WIDTH; b++) begin
                        if (w_entry[SB_MASK_LSB+b]) begin
                            fwd_mask[b]       = 1'b1;
                            fwd_data[8*b +: 8] = w_entry[SB_DATA_LSB+8*b +: 8];
                        end
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/store_drain_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_drain_buffer
// Description : Committed-store buffer between the ROB commit port and the
//               DataCache write port. Queues byte-masked stores in program
//               order and drains them one at a time over mem_req/mem_ack.
//               Optional store-to-load forwarding under STORE_FORWARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module store_drain_buffer
    import store_drain_buffer_pkg::*;
#(
    parameter int DEPTH       = SB_DEPTH,
    parameter int DEPTH_WIDTH = SB_DEPTH_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  st_write,
    input  logic [MASK_WIDTH-1:0] st_mask,
    input  logic [ADDR_WIDTH-1:0] st_addr,
    input  logic [DATA_WIDTH-1:0] st_data,
    output logic                  st_ready,
    output logic                  sb_empty,
    output logic                  mem_req,
    output logic [MASK_WIDTH-1:0] mem_mask,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic                  ld_check,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    output logic [MASK_WIDTH-1:0] fwd_mask,
    output logic [DATA_WIDTH-1:0] fwd_data
);

    localparam logic [DEPTH_WIDTH:0]   c_count_full = (DEPTH_WIDTH+1)'(DEPTH);
    localparam logic [DEPTH_WIDTH:0]   c_count_one  = (DEPTH_WIDTH+1)'(1);
    localparam logic [DEPTH_WIDTH-1:0] c_ptr_one    = DEPTH_WIDTH'(1);

    logic [SB_ENTRY_WIDTH-1:0] r_entries [DEPTH];
    logic [DEPTH_WIDTH-1:0]    r_rd_ptr;
    logic [DEPTH_WIDTH-1:0]    r_wr_ptr;
    logic [DEPTH_WIDTH:0]      r_count;
    sb_state_t                 r_state;
    sb_state_t                 w_state_next;

    logic                      r_mem_req;
    logic [MASK_WIDTH-1:0]     r_mem_mask;
    logic [ADDR_WIDTH-1:0]     r_mem_addr;
    logic [DATA_WIDTH-1:0]     r_mem_wdata;

    logic                      w_push;
    logic                      w_pop;
    logic                      w_load;
    logic                      w_sel_push;
    logic [DEPTH_WIDTH-1:0]    w_head_idx;
    logic [SB_ENTRY_WIDTH-1:0] w_head_entry;

    // Full is decided by count alone; a same-cycle pop does not free a slot.
    assign st_ready  = (r_count != c_count_full);
    assign sb_empty  = (r_count == '0) && (r_state == SB_IDLE);
    assign w_push    = st_write && st_ready;
    assign w_pop     = (r_state == SB_REQ) && mem_ack;

    assign mem_req   = r_mem_req;
    assign mem_mask  = r_mem_mask;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // Entry storage; only slots below count are ever read, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_entries[r_wr_ptr] <= sb_pack(st_mask, st_addr, st_data);
        end
    end

    // Ring pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_count_one;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_count_one;
            end
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Drain FSM next state and head-load selection.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_sel_push   = 1'b0;
        w_head_idx   = r_rd_ptr;
        case (r_state)
            SB_IDLE: begin
                if (r_count != '0) begin
                    w_state_next = SB_REQ;
                    w_load       = 1'b1;
                end
            end
            SB_REQ: begin
                if (mem_ack) begin
                    if (r_count != c_count_one) begin
                        // Next queued store follows without a bubble.
                        w_load     = 1'b1;
                        w_head_idx = r_rd_ptr + c_ptr_one;
                    end else if (w_push) begin
                        // Queue drains this cycle; the incoming store becomes head.
                        w_load     = 1'b1;
                        w_sel_push = 1'b1;
                    end else begin
                        w_state_next = SB_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = SB_IDLE;
            end
        endcase
        w_head_entry = w_sel_push ? sb_pack(st_mask, st_addr, st_data)
                                  : r_entries[w_head_idx];
    end

    // Registered DataCache request, held stable until acknowledged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_req   <= 1'b0;
            r_mem_mask  <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_load) begin
            r_mem_req   <= 1'b1;
            r_mem_mask  <= w_head_entry[SB_MASK_MSB:SB_MASK_LSB];
            r_mem_addr  <= w_head_entry[SB_ADDR_MSB:SB_ADDR_LSB];
            r_mem_wdata <= w_head_entry[SB_DATA_MSB:SB_DATA_LSB];
        end else if (w_state_next == SB_IDLE) begin
            r_mem_req   <= 1'b0;
        end
    end

`ifdef STORE_FORWARD_EN
    logic [DEPTH*SB_ENTRY_WIDTH-1:0] w_entries_flat;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
        assign w_entries_flat[gi*SB_ENTRY_WIDTH +: SB_ENTRY_WIDTH] = r_entries[gi];
    end

    sb_forward_merge #(
        .DEPTH       (DEPTH),
        .DEPTH_WIDTH (DEPTH_WIDTH)
    ) u_fwd (
        .entries  (w_entries_flat),
        .rd_ptr   (r_rd_ptr),
        .count    (r_count),
        .ld_check (ld_check),
        .ld_addr  (ld_addr),
        .fwd_mask (fwd_mask),
        .fwd_data (fwd_data)
    );
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ld_check ^ (^ld_addr);
    assign fwd_mask     = '0;
    assign fwd_data     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_drain_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_drain_buffer
// Description : Directed self-checking bench for store_drain_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_drain_buffer;

`ifdef STORE_FORWARD_EN
    localparam bit c_fwd_on = 1'b1;
`else
    localparam bit c_fwd_on = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        st_write;
    logic [3:0]  st_mask;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        sb_empty;
    logic        mem_req;
    logic [3:0]  mem_mask;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        ld_check;
    logic [31:0] ld_addr;
    logic [3:0]  fwd_mask;
    logic [31:0] fwd_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    store_drain_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .st_write  (st_write),
        .st_mask   (st_mask),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_ready  (st_ready),
        .sb_empty  (sb_empty),
        .mem_req   (mem_req),
        .mem_mask  (mem_mask),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .ld_check  (ld_check),
        .ld_addr   (ld_addr),
        .fwd_mask  (fwd_mask),
        .fwd_data  (fwd_data)
    );

    task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_store(input logic [3:0] m, input logic [31:0] a, input logic [31:0] d);
        st_write = 1'b1;
        st_mask  = m;
        st_addr  = a;
        st_data  = d;
    endtask

    initial begin
        rst = 1'b1; st_write = 1'b0; st_mask = '0; st_addr = '0; st_data = '0;
        mem_ack = 1'b0; ld_check = 1'b0; ld_addr = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_st_ready", st_ready, 1);
        check("rst_sb_empty", sb_empty, 1);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_mask", mem_mask, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_fwd_mask", fwd_mask, 0);

        // 1: single store with ack held high
        mem_ack = 1'b1;
        drive_store(4'hF, 32'h100, 32'hDEADBEEF);
        tick();
        st_write = 1'b0;
        check("t1_req_not_yet", mem_req, 0);
        check("t1_not_empty", sb_empty, 0);
        tick();
        check("t1_req", mem_req, 1);
        check("t1_addr", mem_addr, 32'h100);
        check("t1_data", mem_wdata, 32'hDEADBEEF);
        check("t1_mask", mem_mask, 4'hF);
        tick();
        check("t1_req_drop", mem_req, 0);
        check("t1_empty", sb_empty, 1);
        mem_ack = 1'b0;

        // 2: fill to full, drop a fifth store, drain back-to-back
        drive_store(4'hF, 32'h10, 32'h11111111); tick();
        drive_store(4'h3, 32'h14, 32'h22222222); tick();
        drive_store(4'hC, 32'h18, 32'h33333333); tick();
        drive_store(4'h1, 32'h1C, 32'h44444444); tick();
        check("t2_full_ready", st_ready, 0);
        drive_store(4'h8, 32'h20, 32'h55555555); tick();
        st_write = 1'b0;
        check("t2_full_ready2", st_ready, 0);
        check("t2_head_addr", mem_addr, 32'h10);
        check("t2_head_mask", mem_mask, 4'hF);
        mem_ack = 1'b1;
        tick();
        check("t2_b2b_req1", mem_req, 1);
        check("t2_b2b_addr1", mem_addr, 32'h14);
        check("t2_b2b_mask1", mem_mask, 4'h3);
        check("t2_ready_after_pop", st_ready, 1);
        tick();
        check("t2_b2b_req2", mem_req, 1);
        check("t2_b2b_addr2", mem_addr, 32'h18);
        check("t2_b2b_data2", mem_wdata, 32'h33333333);
        tick();
        check("t2_b2b_req3", mem_req, 1);
        check("t2_b2b_addr3", mem_addr, 32'h1C);
        tick();
        check("t2_drained_req", mem_req, 0);
        check("t2_drained_empty", sb_empty, 1);
        mem_ack = 1'b0;

        // 3: push and ack together while full
        drive_store(4'hF, 32'h40, 32'hA0); tick();
        drive_store(4'hF, 32'h44, 32'hA1); tick();
        drive_store(4'hF, 32'h48, 32'hA2); tick();
        drive_store(4'hF, 32'h4C, 32'hA3); tick();
        drive_store(4'hF, 32'h50, 32'hA4);
        mem_ack = 1'b1;
        check("t3_ready_low", st_ready, 0);
        tick();
        st_write = 1'b0;
        mem_ack  = 1'b0;
        check("t3_ready_back", st_ready, 1);
        check("t3_addr_next", mem_addr, 32'h44);
        mem_ack = 1'b1;
        tick();
        check("t3_addr_48", mem_addr, 32'h48);
        tick();
        check("t3_addr_4c", mem_addr, 32'h4C);
        tick();
        check("t3_dropped_req", mem_req, 0);
        check("t3_dropped_empty", sb_empty, 1);
        mem_ack = 1'b0;

        // 4: ten push/ack pairs wrap both pointers
        for (int k = 0; k < 10; k++) begin
            drive_store(4'hF, 32'h300 + 32'(4*k), 32'(k));
            tick();
            st_write = 1'b0;
            tick();
            check("t4_req", mem_req, 1);
            check("t4_addr", mem_addr, 32'h300 + 32'(4*k));
            check("t4_data", mem_wdata, 32'(k));
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            check("t4_idle", mem_req, 0);
        end

        // 5: reset with a store in flight and two queued
        drive_store(4'hF, 32'h500, 32'h1); tick();
        drive_store(4'hF, 32'h504, 32'h2); tick();
        drive_store(4'hF, 32'h508, 32'h3); tick();
        st_write = 1'b0;
        check("t5_inflight", mem_req, 1);
        rst     = 1'b1;
        mem_ack = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_req", mem_req, 0);
        check("t5_empty", sb_empty, 1);
        check("t5_ready", st_ready, 1);
        check("t5_addr", mem_addr, 0);
        tick();
        check("t5_ack_ignored_req", mem_req, 0);
        check("t5_ack_ignored_empty", sb_empty, 1);
        mem_ack = 1'b0;

        // 6: forwarding lookup
        drive_store(4'b0001, 32'h200, 32'h000000AA); tick();
        drive_store(4'b0010, 32'h200, 32'h0000BB00); tick();
        st_write = 1'b0;
        ld_check = 1'b1;
        ld_addr  = 32'h200;
        #1;
        check("t6_fwd_mask", fwd_mask, c_fwd_on ? 4'b0011 : 4'b0000);
        check("t6_fwd_data", fwd_data, c_fwd_on ? 32'h0000BBAA : 32'h0);
        ld_addr = 32'h204;
        #1;
        check("t6_miss_mask", fwd_mask, 0);
        ld_addr = 32'h200;
        drive_store(4'b0001, 32'h200, 32'h000000CC);
        #1;
        check("t6_same_cycle_mask", fwd_mask, c_fwd_on ? 4'b0011 : 4'b0000);
        check("t6_same_cycle_data", fwd_data, c_fwd_on ? 32'h0000BBAA : 32'h0);
        tick();
        st_write = 1'b0;
        check("t6_young_mask", fwd_mask, c_fwd_on ? 4'b0011 : 4'b0000);
        check("t6_young_data", fwd_data, c_fwd_on ? 32'h0000BBCC : 32'h0);
        ld_check = 1'b0;
        #1;
        check("t6_off_mask", fwd_mask, 0);
        check("t6_off_data", fwd_data, 0);
        mem_ack = 1'b1;
        tick();
        tick();
        tick();
        mem_ack = 1'b0;
        check("t6_drained", sb_empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
